// File: rtl/decode_stage.sv
// RV32I decode stage: decodes at the input and holds results in a 2-entry skid buffer.
// Optional macro DECODE_STAGE_RV32M_EN makes OP funct7=0000001 legal and drives muldiv_o.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int IMM_SRC_W = 3,
  parameter int ALU_OP_W  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instr_i,
  input  logic [XLEN-1:0]      pc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          instr_o,
  output logic [XLEN-1:0]      pc_o,
  output logic                 reg_wr_en_o,
  output logic                 mem_wr_en_o,
  output logic [IMM_SRC_W-1:0] imm_src_o,
  output logic                 alu_src_o,
  output logic                 alu_src_a_o,
  output logic                 branch_o,
  output logic                 jump_o,
  output logic [1:0]           result_src_o,
  output logic [ALU_OP_W-1:0]  alu_op_o,
  output logic                 muldiv_o,
  output logic                 illegal_o
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_wr;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       alu_src_a;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       muldiv;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  state_t state_reg;
  logic   in_ready_reg;
  logic   out_valid_reg;
  entry_t head_reg;
  entry_t skid_reg;
  ctrl_t  dec_ctrl;
  entry_t in_entry;
  logic   bad;
  logic   accept;
  logic   pop;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    dec_ctrl = '0;
    bad      = 1'b0;
    case (opcode)
      7'b0000011: begin
        dec_ctrl.reg_wr     = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.result_src = 2'b01;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      7'b0010011: begin
        dec_ctrl.reg_wr  = 1'b1;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.alu_op  = 2'b10;
        if (funct3 == 3'b001) begin
          dec_ctrl.imm_src = 3'b101;
          bad = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec_ctrl.imm_src = 3'b101;
          bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end
      end
      7'b0100011: begin
        dec_ctrl.mem_wr  = 1'b1;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.imm_src = 3'b001;
        bad = (funct3 > 3'b010);
      end
      7'b0110011: begin
        dec_ctrl.reg_wr = 1'b1;
        dec_ctrl.alu_op = 2'b10;
        if (funct7 == 7'b0000000) begin
          bad = 1'b0;
        end else if (funct7 == 7'b0100000) begin
          bad = (funct3 != 3'b000) && (funct3 != 3'b101);
        end
`ifdef DECODE_STAGE_RV32M_EN
        else if (funct7 == 7'b0000001) begin
          dec_ctrl.muldiv = 1'b1;
        end
`endif
        else begin
          bad = 1'b1;
        end
      end
      7'b1100011: begin
        dec_ctrl.branch  = 1'b1;
        dec_ctrl.alu_op  = 2'b01;
        dec_ctrl.imm_src = 3'b010;
        bad = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      7'b1101111: begin
        dec_ctrl.jump       = 1'b1;
        dec_ctrl.reg_wr     = 1'b1;
        dec_ctrl.result_src = 2'b10;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.alu_src_a  = 1'b1;
        dec_ctrl.imm_src    = 3'b100;
      end
      7'b1100111: begin
        dec_ctrl.jump       = 1'b1;
        dec_ctrl.reg_wr     = 1'b1;
        dec_ctrl.result_src = 2'b10;
        dec_ctrl.alu_src    = 1'b1;
        bad = (funct3 != 3'b000);
      end
      7'b0110111: begin
        dec_ctrl.reg_wr  = 1'b1;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.alu_op  = 2'b11;
        dec_ctrl.imm_src = 3'b011;
      end
      7'b0010111: begin
        dec_ctrl.reg_wr    = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_src_a = 1'b1;
        dec_ctrl.imm_src   = 3'b011;
      end
      default: bad = 1'b1;
    endcase
    // An illegal beat carries no side-effecting controls downstream.
    if (bad) begin
      dec_ctrl         = '0;
      dec_ctrl.illegal = 1'b1;
    end
  end

  assign in_entry = '{ctrl: dec_ctrl, instr: instr_i, pc: pc_i};
  assign accept   = in_valid_i & in_ready_reg & ~flush_i;
  assign pop      = out_valid_reg & out_ready_i & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      head_reg      <= '0;
      skid_reg      <= '0;
    end else if (flush_i) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      head_reg      <= '0;
      skid_reg      <= '0;
    end else begin
      case (state_reg)
        EMPTY: if (accept) begin
          head_reg      <= in_entry;
          state_reg     <= ONE;
          out_valid_reg <= 1'b1;
        end
        ONE: begin
          if (accept && !pop) begin
            skid_reg     <= in_entry;
            state_reg    <= TWO;
            in_ready_reg <= 1'b0;
          end else if (!accept && pop) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
          end else if (accept && pop) begin
            head_reg <= in_entry;
          end
        end
        TWO: if (pop) begin
          head_reg     <= skid_reg;
          state_reg    <= ONE;
          in_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_reg;
  assign out_valid_o  = out_valid_reg;
  assign instr_o      = head_reg.instr;
  assign pc_o         = head_reg.pc;
  assign reg_wr_en_o  = head_reg.ctrl.reg_wr;
  assign mem_wr_en_o  = head_reg.ctrl.mem_wr;
  assign imm_src_o    = IMM_SRC_W'(head_reg.ctrl.imm_src);
  assign alu_src_o    = head_reg.ctrl.alu_src;
  assign alu_src_a_o  = head_reg.ctrl.alu_src_a;
  assign branch_o     = head_reg.ctrl.branch;
  assign jump_o       = head_reg.ctrl.jump;
  assign result_src_o = head_reg.ctrl.result_src;
  assign alu_op_o     = ALU_OP_W'(head_reg.ctrl.alu_op);
  assign muldiv_o     = head_reg.ctrl.muldiv;
  assign illegal_o    = head_reg.ctrl.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode stage for the RV32I core; the successor to the purely combinational main decoder.
- Decodes a full 32-bit instruction into control fields, flags illegal encodings and carries PC/instruction alongside.
- Buffers results in a 2-entry skid buffer with valid/ready on both sides, so the stage sits between fetch and execute with full throughput and registered outputs.

Parameters:
- XLEN, 32, width of pc_i/pc_o.
- IMM_SRC_W, 3, width of imm_src_o (must be >= 3).
- ALU_OP_W, 2, width of alu_op_o (must be >= 2; upper bits zero-filled).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous flush: drops buffered entries and any input beat in the same cycle.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  stage can accept a beat.
- instr_i  in  32  instruction word.
- pc_i  in  XLEN  instruction address.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts head.
- instr_o  out  32  head instruction.
- pc_o  out  XLEN  head PC.
- reg_wr_en_o  out  1  register write enable.
- mem_wr_en_o  out  1  memory write enable.
- imm_src_o  out  IMM_SRC_W  immediate type: I=000, S=001, B=010, U=011, J=100, shamt=101.
- alu_src_o  out  1  ALU B operand: 0=rs2, 1=imm.
- alu_src_a_o  out  1  ALU A operand: 0=rs1, 1=PC.
- branch_o  out  1  conditional branch.
- jump_o  out  1  JAL/JALR.
- result_src_o  out  2  writeback source: 00=ALU, 01=mem, 10=PC+4.
- alu_op_o  out  ALU_OP_W  00=add, 01=sub/compare, 10=funct-decoded, 11=pass B.
- muldiv_o  out  1  M-extension op (0 unless feature enabled).
- illegal_o  out  1  illegal encoding.

Behaviour:
- Reset: state EMPTY; in_ready_o=1; out_valid_o=0; all control outputs, instr_o and pc_o are 0.
- State machine (entry count): EMPTY, ONE, TWO.
  - in_ready_o = (state != TWO); depends on state only, never combinationally on out_ready_i.
  - Accept = in_valid_i & in_ready_o & !flush_i.
  - Pop = out_valid_o & out_ready_i & !flush_i.
  - EMPTY: accept -> ONE.
  - ONE: accept & !pop -> TWO; !accept & pop -> EMPTY; accept & pop -> ONE, new beat becomes head.
  - TWO: pop -> ONE, skid entry promoted to head; no accept possible.
  - flush_i has priority over all events: next state EMPTY, outputs zeroed as at reset.
- Latency: decode is performed on instr_i at the input and stored. A beat accepted in cycle N appears on the outputs in cycle N+1.
- Ordering is FIFO. Sustained in_valid_i=out_ready_i=1 gives one beat per cycle.
- Outputs are held stable while out_valid_o=1 and out_ready_i=0.
- Decode table:
  - Load 0000011: reg_wr, alu_src, result 01, imm I.
  - OP-IMM 0010011: reg_wr, alu_src, alu_op 10, imm shamt for funct3 001/101, else I.
  - Store 0100011: mem_wr, alu_src, imm S.
  - OP 0110011: reg_wr, alu_op 10.
  - Branch 1100011: branch, alu_op 01, imm B.
  - JAL 1101111: jump, reg_wr, result 10, alu_src, alu_src_a=1, imm J.
  - JALR 1100111: jump, reg_wr, result 10, alu_src, imm I.
  - LUI 0110111: reg_wr, alu_src, alu_op 11, imm U.
  - AUIPC 0010111: reg_wr, alu_src, alu_src_a=1, alu_op 00, imm U.
- Illegal when any of the following holds:
  - Unlisted opcode.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 > 010.
  - Branch funct3 in {010, 011}.
  - JALR funct3 != 000.
  - OP funct7 not 0000000, or 0100000 with funct3 other than 000/101.
  - SLLI funct7 != 0000000.
  - SRLI/SRAI funct7 not 0000000/0100000.
- For an illegal beat: illegal_o=1 and every other control output is 0. The beat still flows through the handshake.
- in_valid_i=0: instr_i and pc_i are ignored.

Optional Feature:
- Macro: DECODE_STAGE_RV32M_EN.
- Defined: OP with funct7=0000001 (any funct3) is legal; outputs reg_wr=1, alu_op=10, muldiv_o=1.
- Undefined: that encoding is illegal and muldiv_o is tied to 0.

Test Plan:
- Reset mid-stream: assert rst_i while in TWO -> out_valid_o=0, in_ready_o=1, all outputs 0 immediately (no clock needed).
- Single beat: instr_i=0x00A00093 (addi x1,x0,10), pc_i=0x100 accepted in cycle N -> cycle N+1: out_valid_o=1, reg_wr=1, alu_src=1, alu_op=10, imm_src=000, pc_o=0x100.
- Backpressure: out_ready_i=0, push 3 beats (0x00000013, 0x0000006F, 0x00002083) -> first two accepted, in_ready_o=0 on the third. Release out_ready_i -> they pop in order. The JAL beat shows jump=1, result=10, alu_src_a=1, imm_src=100.
- Illegal: 0x00003003 (ld), 0x00002063, 0xFFFFFFFF -> illegal_o=1 and all other controls 0 for each beat.
- Flush: state TWO with in_valid_i=1 and flush_i=1 -> next cycle EMPTY, out_valid_o=0, input beat dropped.
- Feature: 0x02208033 (mul) -> macro defined: muldiv_o=1, illegal_o=0; macro undefined: illegal_o=1, muldiv_o=0.
